// File: rtl/nibble_serial_la_subtractor.sv
// Multi-cycle A - B - bin subtractor. One 4-bit nibble per clock, LSB nibble
// first, through a look-ahead borrow slice; a registered borrow links the
// nibbles. Valid/ready handshake on both the operand and the result side.
module nibble_serial_la_subtractor #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             zero,
    output logic             ovf
);

    localparam int NNIB = WIDTH / 4;
    localparam int CW   = (NNIB > 1) ? $clog2(NNIB) : 1;

    generate
        if (WIDTH < 4 || (WIDTH % 4) != 0) begin : g_bad_width
            $error("nibble_serial_la_subtractor: WIDTH must be a multiple of 4 and >= 4");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_reg, state_next;
    logic [WIDTH-1:0] a_sh_reg, b_sh_reg;
    logic [WIDTH-1:0] diff_reg, diff_next;
    logic             a_msb_reg, b_msb_reg;
    logic             borrow_reg;
    logic             bout_reg, zero_reg, ovf_reg;
    logic [CW-1:0]    cnt_reg;

    // Nibble slice signals
    logic [3:0] an, bn, g, p, br, d;
    logic       br4;
    logic       accept, last_nib;

    // Operands are shifted down each step, so the active nibble is always [3:0]
    assign an = a_sh_reg[3:0];
    assign bn = b_sh_reg[3:0];
    assign g  = ~an & bn;
    assign p  = ~(an ^ bn);

    // Look-ahead expanded borrows: each one depends only on g/p and borrow_reg
    assign br[0] = borrow_reg;
    assign br[1] = g[0] | (p[0] & borrow_reg);
    assign br[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & borrow_reg);
    assign br[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
                 | (p[2] & p[1] & p[0] & borrow_reg);
    assign br4   = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
                 | (p[3] & p[2] & p[1] & g[0])
                 | (p[3] & p[2] & p[1] & p[0] & borrow_reg);
    assign d     = an ^ bn ^ br;

    assign accept   = (state_reg == IDLE) && in_valid;
    assign last_nib = (cnt_reg == CW'(NNIB - 1));

    // The nibble addressed by the counter takes the slice result during CALC;
    // all other nibbles keep their current value.
    generate
        for (genvar gi = 0; gi < NNIB; gi++) begin : g_nib
            assign diff_next[4*gi +: 4] =
                ((state_reg == CALC) && (cnt_reg == CW'(gi))) ? d : diff_reg[4*gi +: 4];
        end
    endgenerate

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic and handshake outputs
    always_comb begin
        state_next = state_reg;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        case (state_reg)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_next = CALC;
            end
            CALC: begin
                if (last_nib) state_next = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Operand latch, nibble stepping and result flags
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_sh_reg   <= '0;
            b_sh_reg   <= '0;
            a_msb_reg  <= 1'b0;
            b_msb_reg  <= 1'b0;
            borrow_reg <= 1'b0;
            cnt_reg    <= '0;
            diff_reg   <= '0;
            bout_reg   <= 1'b0;
            zero_reg   <= 1'b0;
            ovf_reg    <= 1'b0;
        end else if (accept) begin
            a_sh_reg   <= a;
            b_sh_reg   <= b;
            a_msb_reg  <= a[WIDTH-1];
            b_msb_reg  <= b[WIDTH-1];
            borrow_reg <= bin;
            cnt_reg    <= '0;
            diff_reg   <= '0;
        end else if (state_reg == CALC) begin
            a_sh_reg   <= a_sh_reg >> 4;
            b_sh_reg   <= b_sh_reg >> 4;
            borrow_reg <= br4;
            cnt_reg    <= cnt_reg + CW'(1);
            diff_reg   <= diff_next;
            if (last_nib) begin
                bout_reg <= br4;
                zero_reg <= (diff_next == '0);
                ovf_reg  <= (a_msb_reg != b_msb_reg) && (diff_next[WIDTH-1] != a_msb_reg);
            end
        end
    end

    assign diff = diff_reg;
    assign bout = bout_reg;
    assign zero = zero_reg;
    assign ovf  = ovf_reg;

endmodule
